// File: rtl/dmem_responder.sv
// Data-memory responder for a MEM pipeline stage: a word array behind a
// req/ack handshake, with optional wait states and alignment/range checks.
module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_req,
    input  logic        in_we,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_busy,
    output logic        out_ack,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic [1:0]  o_dbg_state
);

    // Handshake: the requester raises in_req with stable fields and holds it
    // until out_ack; everything is latched on the accepting edge in IDLE.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_busy;
    logic                r_ack;
    logic [31:0]         r_rdata;
    logic                r_err;

    logic [31:0]         r_mem [0:(2**ADDR_W)-1];

    logic                w_err;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
    logic [3:0]          w_be;
    logic [31:0]         w_wlanes;
    logic                w_wr_en;

    always_comb begin
        w_err = 1'b0;
        if (in_size == 2'b11) w_err = 1'b1;
        if (in_size == 2'b01 && in_addr[0]) w_err = 1'b1;
        if (in_size == 2'b10 && in_addr[1:0] != 2'b00) w_err = 1'b1;
        if ((in_addr >> (ADDR_W + 2)) != 32'd0) w_err = 1'b1;
    end

    assign w_word = r_mem[r_addr[ADDR_W+1:2]];
    assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'd0;
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            2'b10:   w_load = w_word;
            default: w_load = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = 32'd0;
        case (r_size)
            2'b00: begin
                w_be     = 4'b0001 << r_addr[1:0];
                w_wlanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
            end
            default: begin
                w_be     = 4'b0000;
                w_wlanes = 32'd0;
            end
        endcase
    end

    assign w_wr_en = !rst && (r_state == S_ACCESS) && r_we;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[r_addr[ADDR_W+1:2]][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack   <= 1'b0;
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                    if (in_req) begin
                        r_we       <= in_we;
                        r_size     <= in_size;
                        r_unsigned <= in_unsigned;
                        r_addr     <= in_addr[ADDR_W+1:0];
                        r_wdata    <= in_wdata;
                        r_busy     <= 1'b1;
                        if (w_err) begin
                            r_state <= S_RESP;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (WAIT > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_RESP;
                    r_ack   <= 1'b1;
                    r_err   <= 1'b0;
                    r_rdata <= r_we ? 32'd0 : w_load;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ack   <= 1'b0;
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_busy    = r_busy;
    assign out_ack     = r_ack;
    assign out_rdata   = r_rdata;
    assign out_err     = r_err;
    assign o_dbg_state = r_state;

endmodule
